// File: rtl/bpf_sequencer_pkg.sv
// Shared definitions for the BPF relay sequencer: relay codes, band
// thresholds (freq units of 65536 Hz) and the sequencer state encoding.
package bpf_sequencer_pkg;

    localparam int CNT_W = 16;

    localparam logic [2:0] BPF_0_2M5    = 3'd6;
    localparam logic [2:0] BPF_2M5_6M   = 3'd2;
    localparam logic [2:0] BPF_6M_12M5  = 3'd0;
    localparam logic [2:0] BPF_12M5_20M = 3'd3;
    localparam logic [2:0] BPF_20_30M   = 3'd1;
    localparam logic [2:0] BPF_OFF      = 3'd7;

    // Inclusive upper limit of each band
    localparam logic [15:0] BAND_TH_2M5  = 16'd38;
    localparam logic [15:0] BAND_TH_6M   = 16'd91;
    localparam logic [15:0] BAND_TH_12M5 = 16'd191;
    localparam logic [15:0] BAND_TH_20M  = 16'd305;

    typedef enum logic [2:0] {
        ST_START,
        ST_IDLE,
        ST_MUTE,
        ST_BREAK,
        ST_SET,
        ST_SETTLE
    } state_t;

endpackage

// File: rtl/bpf_band_lut.sv
// Combinational tuned-frequency to BPF relay code decode. Shared with the
// TX LPF path, so it stays unregistered.
module bpf_band_lut
    import bpf_sequencer_pkg::*;
(
    input  logic [15:0] freq,
    output logic [2:0]  code
);

    // Unsigned inclusive threshold search, lowest band first
    always_comb begin
        code = BPF_20_30M;
        if (freq <= BAND_TH_2M5)
            code = BPF_0_2M5;
        else if (freq <= BAND_TH_6M)
            code = BPF_2M5_6M;
        else if (freq <= BAND_TH_12M5)
            code = BPF_6M_12M5;
        else if (freq <= BAND_TH_20M)
            code = BPF_12M5_20M;
    end

endmodule

// File: rtl/bpf_sequencer.sv
// Break-before-make BPF relay sequencer. Mutes receive audio, opens all
// relays, closes the new one and waits for contacts to settle. New bands
// are only started from IDLE with ptt low.
module bpf_sequencer
    import bpf_sequencer_pkg::*;
#(
    parameter int         MUTE_CYC   = 64,
    parameter int         BREAK_CYC  = 256,
    parameter int         SETTLE_CYC = 4096,
    parameter logic [2:0] OFF_CODE   = BPF_OFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] freq,
    input  logic        ptt,
    output logic [2:0]  bpf,
    output logic        mute,
    output logic        busy
);

    localparam logic [CNT_W-1:0] MUTE_LOAD   = CNT_W'(MUTE_CYC - 1);
    localparam logic [CNT_W-1:0] BREAK_LOAD  = CNT_W'(BREAK_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

    logic [2:0]       band_code;
    logic [2:0]       target;
    logic [2:0]       applied;
    logic [2:0]       bpf_next;
    logic             mute_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load;
    state_t           state;
    state_t           state_next;

    bpf_band_lut u_lut (
        .freq (freq),
        .code (band_code)
    );

    // Register the decoded band every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            target <= OFF_CODE;
        else
            target <= band_code;
    end

    // State register plus dwell counter, reloaded whenever a state is entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_START;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                cnt <= cnt_load;
            else if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
        end
    end

    // Registered relay, mute and busy outputs, plus the applied band
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bpf     <= OFF_CODE;
            mute    <= 1'b1;
            busy    <= 1'b1;
            applied <= OFF_CODE;
        end else begin
            bpf  <= bpf_next;
            mute <= mute_next;
            busy <= (state_next != ST_IDLE);
            if (state_next == ST_SET)
                applied <= target;
        end
    end

    // Next-state decode and values the output registers take on entry
    always_comb begin
        state_next = state;
        cnt_load   = '0;
        bpf_next   = bpf;
        mute_next  = 1'b1;

        case (state)
            ST_START:  state_next = ST_BREAK;
            ST_IDLE:   if (target != applied && !ptt) state_next = ST_MUTE;
            ST_MUTE:   if (cnt == '0) state_next = ST_BREAK;
            ST_BREAK:  if (cnt == '0) state_next = ST_SET;
            ST_SET:    state_next = ST_SETTLE;
            ST_SETTLE: if (cnt == '0) state_next = (target != applied) ? ST_BREAK : ST_IDLE;
            default:   state_next = ST_START;
        endcase

        case (state_next)
            ST_MUTE:   cnt_load = MUTE_LOAD;
            ST_BREAK:  cnt_load = BREAK_LOAD;
            ST_SETTLE: cnt_load = SETTLE_LOAD;
            default:   cnt_load = '0;
        endcase

        if (state_next == ST_BREAK)
            bpf_next = OFF_CODE;
        else if (state_next == ST_SET)
            bpf_next = target;

        mute_next = (state_next != ST_IDLE);
    end

endmodule

// File: tb/tb_bpf_sequencer.sv
// Self-checking bench for bpf_sequencer with short dwell counts.
module tb_bpf_sequencer;

    localparam int         M   = 4;
    localparam int         B   = 8;
    localparam int         S   = 16;
    localparam logic [2:0] OFF = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] freq;
    logic        ptt;
    logic [2:0]  bpf;
    logic        mute;
    logic        busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [2:0] ref_applied;

    typedef struct {
        int         f;
        logic [2:0] code;
    } vec_t;

    vec_t tbl [0:7];

    bpf_sequencer #(
        .MUTE_CYC   (M),
        .BREAK_CYC  (B),
        .SETTLE_CYC (S)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .freq  (freq),
        .ptt   (ptt),
        .bpf   (bpf),
        .mute  (mute),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Band of a frequency: first band whose upper limit covers it
    function automatic logic [2:0] ref_band(input int f);
        int         lim  [0:3];
        logic [2:0] code [0:4];
        lim  = '{38, 91, 191, 305};
        code = '{3'd6, 3'd2, 3'd0, 3'd3, 3'd1};
        for (int i = 0; i < 4; i++)
            if (f <= lim[i]) return code[i];
        return code[4];
    endfunction

    // Expected waveform of one change whose mute starts at cycle s
    function automatic logic exp_mute(input int k, input int s, input logic [2:0] o, input logic [2:0] n);
        if (o == n) return 1'b0;
        return (k >= s && k <= s + M + B + S);
    endfunction

    function automatic logic [2:0] exp_bpf(input int k, input int s, input logic [2:0] o, input logic [2:0] n);
        if (o == n || k < s + M) return o;
        if (k < s + M + B) return OFF;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] eb, input logic em, input logic ebusy);
        n_tests++;
        if (bpf !== eb || mute !== em || busy !== ebusy) begin
            n_fail++;
            $display("FAIL %s: got bpf=%0d mute=%0b busy=%0b, expected bpf=%0d mute=%0b busy=%0b",
                     name, bpf, mute, busy, eb, em, ebusy);
        end
    endtask

    // Check cycles k1..k2 of a timeline; optional ptt pulse at pk..pk+4
    task automatic seq_check(input string name, input int s, input logic [2:0] o, input logic [2:0] n,
                             input int k1, input int k2, input int pk);
        logic em;
        for (int k = k1; k <= k2; k++) begin
            tick();
            em = exp_mute(k, s, o, n);
            check($sformatf("%s k=%0d", name, k), exp_bpf(k, s, o, n), em, em);
            if (k == pk) ptt = 1'b1;
            if (k == pk + 4) ptt = 1'b0;
        end
    endtask

    task automatic change(input string name, input int f, input int pk);
        logic [2:0] n;
        freq = 16'(f);
        n = ref_band(f);
        seq_check(name, 2, ref_applied, n, 1, 34, pk);
        ref_applied = n;
    endtask

    task automatic flat(input string name, input int cycles);
        for (int k = 1; k <= cycles; k++) begin
            tick();
            check($sformatf("%s k=%0d", name, k), ref_applied, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int f;
        int hold;
        int pk;
        logic [2:0] n;
        logic [2:0] eb;

        tbl = '{'{38, 3'd6}, '{39, 3'd2}, '{91, 3'd2}, '{92, 3'd0},
                '{191, 3'd0}, '{192, 3'd3}, '{305, 3'd3}, '{306, 3'd1}};

        // Reset and first selection
        reset = 1'b1;
        freq  = 16'd100;
        ptt   = 1'b0;
        #3;
        check("reset async", OFF, 1'b1, 1'b1);
        tick();
        tick();
        check("reset held", OFF, 1'b1, 1'b1);
        reset = 1'b0;
        seq_check("start", 1 - M, OFF, ref_band(100), 1, 30, -1);
        ref_applied = ref_band(100);

        // Single change while idle
        change("chg 100-50", 50, -1);

        // New band requested during SETTLE forces a second break
        freq = 16'd100;
        for (int k = 1; k <= 60; k++) begin
            tick();
            eb = (k < 6) ? 3'd2 : (k < 14) ? OFF : (k < 31) ? 3'd0 : (k < 39) ? OFF : 3'd3;
            check($sformatf("rebreak k=%0d", k), eb, (k >= 2 && k <= 55), (k >= 2 && k <= 55));
            if (k == 16) freq = 16'd200;
        end
        ref_applied = 3'd3;

        // Frequency toggles during MUTE/BREAK, single sequence to final band
        freq = 16'd400;
        for (int k = 1; k <= 34; k++) begin
            tick();
            check($sformatf("toggle k=%0d", k), exp_bpf(k, 2, 3'd3, 3'd1),
                  exp_mute(k, 2, 3'd3, 3'd1), exp_mute(k, 2, 3'd3, 3'd1));
            if (k == 4) freq = 16'd200;
            if (k == 7) freq = 16'd400;
        end
        ref_applied = 3'd1;

        // ptt rising mid-sequence does not stop it
        change("ptt mid", 200, 5);

        // ptt held defers the change; release starts it next clock
        ptt  = 1'b1;
        freq = 16'd400;
        flat("ptt hold", 40);
        ptt = 1'b0;
        seq_check("ptt fall", 1, 3'd3, 3'd1, 1, 33, -1);
        ref_applied = 3'd1;

        // Boundary table
        for (int i = 0; i < 8; i++) begin
            change($sformatf("bound %0d", tbl[i].f), tbl[i].f, -1);
            check($sformatf("bound code %0d", tbl[i].f), tbl[i].code, 1'b0, 1'b0);
        end

        // Randomized changes against the reference timeline
        for (int i = 0; i < 10; i++) begin
            f = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 700)) : int'($urandom_range(30, 320));
            if ($urandom_range(0, 2) == 0) begin
                hold = $urandom_range(3, 12);
                ptt  = 1'b1;
                freq = 16'(f);
                flat($sformatf("rnd%0d hold f=%0d", i, f), hold);
                ptt = 1'b0;
                n = ref_band(f);
                seq_check($sformatf("rnd%0d rel f=%0d", i, f), 1, ref_applied, n, 1, 33, -1);
                ref_applied = n;
            end else begin
                pk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 20)) : -1;
                change($sformatf("rnd%0d f=%0d", i, f), f, pk);
            end
        end

        // Reset pulse during SETTLE
        f = (ref_applied == 3'd0) ? 50 : 100;
        n = ref_band(f);
        freq = 16'(f);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("pre-rst k=%0d", k), exp_bpf(k, 2, ref_applied, n),
                  exp_mute(k, 2, ref_applied, n), exp_mute(k, 2, ref_applied, n));
        end
        reset = 1'b1;
        #1;
        check("mid reset async", OFF, 1'b1, 1'b1);
        tick();
        check("mid reset held", OFF, 1'b1, 1'b1);
        reset = 1'b0;
        seq_check("restart", 1 - M, OFF, n, 1, 30, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
